// File: rtl/ones_count_operand_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ones_count_operand_feeder_pkg
// Description : Shared definitions for the ones-counter operand feeder:
//               default operand width / window lengths (also used by the
//               ASM_counter bench), FSM state encoding and a small helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ones_count_operand_feeder_pkg;

    // Defaults shared with the downstream ASM_counter environment
    localparam int C_WIDTH       = 8;
    localparam int C_HOLD_CYCLES = 10;
    localparam int C_GAP_CYCLES  = 2;

    // FSM state encoding
    localparam logic [1:0] C_ST_SHIFT = 2'd0;
    localparam logic [1:0] C_ST_SETUP = 2'd1;
    localparam logic [1:0] C_ST_HOLD  = 2'd2;
    localparam logic [1:0] C_ST_GAP   = 2'd3;

    typedef enum logic [1:0] {
        ST_SHIFT = C_ST_SHIFT,
        ST_SETUP = C_ST_SETUP,
        ST_HOLD  = C_ST_HOLD,
        ST_GAP   = C_ST_GAP
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : ones_count_operand_feeder_pkg
`default_nettype wire

// File: rtl/ones_count_operand_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : ones_count_operand_feeder_if
// Description : Signal bundle between a serial bit source, the operand feeder
//               and the downstream ones counter.
//   ser_in/ser_valid/ser_ready : serial bit handshake (MSB first)
//   inA/s                      : operand and start/hold to ASM_counter
//   busy/overrun/ovr_clr       : status and sticky overrun clear
//   modport master : serial source / status consumer
//   modport slave  : the operand feeder itself
// Revision    : 1.0 - initial release
// ============================================================================
interface ones_count_operand_feeder_if
    import ones_count_operand_feeder_pkg::*;
#(
    parameter int WIDTH = C_WIDTH
) ();

    logic             ser_in;
    logic             ser_valid;
    logic             ser_ready;
    logic [WIDTH-1:0] inA;
    logic             s;
    logic             busy;
    logic             overrun;
    logic             ovr_clr;

    modport master (
        output ser_in, ser_valid, ovr_clr,
        input  ser_ready, inA, s, busy, overrun
    );

    modport slave (
        input  ser_in, ser_valid, ovr_clr,
        output ser_ready, inA, s, busy, overrun
    );

endinterface : ones_count_operand_feeder_if
`default_nettype wire

// File: rtl/ones_count_operand_feeder_ser_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : ones_count_operand_feeder_ser_shift_reg
// Description : Serial-in/parallel-out shifter with bit counter.
//   clk, rs        : clock, asynchronous active-high reset
//   i_en           : accept i_bit this cycle
//   i_bit          : serial bit, MSB first
//   o_next_word    : word as it would read after shifting in i_bit
//   o_word_done    : i_en on the WIDTH-th bit of a word
// Revision    : 1.0 - initial release
// ============================================================================
module ones_count_operand_feeder_ser_shift_reg #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rs,
    input  wire logic             i_en,
    input  wire logic             i_bit,
    output logic      [WIDTH-1:0] o_next_word,
    output logic                  o_word_done
);

    localparam int CNT_W = $clog2(WIDTH);

    // Only WIDTH-1 bits are stored: the oldest bit would be shifted out on the
    // very edge that could first observe it, so it never needs a flop.
    logic [WIDTH-2:0] r_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             w_last_bit;

    assign o_next_word = {r_shift, i_bit};
    assign w_last_bit  = (r_bit_cnt == CNT_W'(WIDTH - 1));
    assign o_word_done = i_en & w_last_bit;

    // Partial words persist across idle cycles; only reset discards them.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (i_en) begin
            r_shift   <= o_next_word[WIDTH-2:0];
            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end

endmodule : ones_count_operand_feeder_ser_shift_reg
`default_nettype wire

// File: rtl/ones_count_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : ones_count_operand_feeder
// Description : Assembles a WIDTH-bit operand from a serial stream and drives
//               the ASM_counter inA/s pair: inA is presented with s=0 for one
//               load cycle, s is then held high for HOLD_CYCLES and dropped
//               for GAP_CYCLES before the next operand is accepted.
//   clk  : clock (rising edge)
//   rs   : asynchronous active-high reset
//   bus  : slave modport - ser_in/ser_valid/ser_ready, inA, s, busy,
//          overrun, ovr_clr
//   All interface outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module ones_count_operand_feeder
    import ones_count_operand_feeder_pkg::*;
#(
    parameter int WIDTH       = C_WIDTH,
    parameter int HOLD_CYCLES = C_HOLD_CYCLES,
    parameter int GAP_CYCLES  = C_GAP_CYCLES
) (
    input  wire logic                  clk,
    input  wire logic                  rs,
    ones_count_operand_feeder_if.slave bus
);

    localparam int C_TMR_MAX = max_int(HOLD_CYCLES, GAP_CYCLES);
    localparam int TMR_W     = $clog2(C_TMR_MAX + 1);

    // The counter needs WIDTH+2 cycles of s=1 to finish; a zero gap would
    // never let it see s=0 between operands.
    generate
        if ((HOLD_CYCLES < WIDTH + 2) || (GAP_CYCLES < 1)) begin : g_param_check
            $error("ones_count_operand_feeder: HOLD_CYCLES must be >= WIDTH+2 and GAP_CYCLES >= 1");
        end
    endgenerate

    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic [WIDTH-1:0] r_inA;
    logic             r_s;
    logic             r_ready;
    logic             r_busy;
    logic             r_overrun;

    logic             w_accept;
    logic [WIDTH-1:0] w_next_word;
    logic             w_word_done;

    // r_ready is high exactly while in SHIFT, so this is the accept qualifier.
    assign w_accept = bus.ser_valid & r_ready;

    ones_count_operand_feeder_ser_shift_reg #(
        .WIDTH (WIDTH)
    ) u_ser_shift_reg (
        .clk         (clk),
        .rs          (rs),
        .i_en        (w_accept),
        .i_bit       (bus.ser_in),
        .o_next_word (w_next_word),
        .o_word_done (w_word_done)
    );

    // FSM, hold/gap timer and all registered outputs.
    // ser_ready/busy are loaded with the decode of the state being entered.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            r_state   <= ST_SHIFT;
            r_timer   <= '0;
            r_inA     <= '0;
            r_s       <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // Sticky overrun; clear takes priority over a same-cycle set.
            if (bus.ovr_clr) begin
                r_overrun <= 1'b0;
            end else if (bus.ser_valid && !r_ready) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_SHIFT: begin
                    if (w_word_done) begin
                        r_inA   <= w_next_word;
                        r_state <= ST_SETUP;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                // One s=0 cycle with inA valid: the counter's load cycle.
                ST_SETUP: begin
                    r_s     <= 1'b1;
                    r_timer <= TMR_W'(HOLD_CYCLES);
                    r_state <= ST_HOLD;
                end
                // Timer is loaded on entry and leaves the state when it reads 1.
                ST_HOLD: begin
                    if (r_timer == TMR_W'(1)) begin
                        r_s     <= 1'b0;
                        r_timer <= TMR_W'(GAP_CYCLES);
                        r_state <= ST_GAP;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_timer == TMR_W'(1)) begin
                        r_state <= ST_SHIFT;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_SHIFT;
                    r_s     <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inA       = r_inA;
    assign bus.s         = r_s;
    assign bus.ser_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.overrun   = r_overrun;

endmodule : ones_count_operand_feeder
`default_nettype wire

// File: tb/tb_ones_count_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ones_count_operand_feeder
// Description : Self-checking bench for ones_count_operand_feeder. Words are
//               pushed to a scoreboard when their last bit is driven and
//               popped when s rises; a small ones-counter model stands in
//               for ASM_counter downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ones_count_operand_feeder;
    import ones_count_operand_feeder_pkg::*;

    localparam int C_W    = 8;
    localparam int C_HOLD = 10;
    localparam int C_GAP  = 2;

    logic clk = 1'b0;
    logic rs;
    always #5 clk = ~clk;

    ones_count_operand_feeder_if #(.WIDTH(C_W)) bus ();

    ones_count_operand_feeder #(
        .WIDTH       (C_W),
        .HOLD_CYCLES (C_HOLD),
        .GAP_CYCLES  (C_GAP)
    ) dut (
        .clk (clk),
        .rs  (rs),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [C_W-1:0] q_exp[$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Downstream ones-counter model: loads inA while s=0, counts while s=1.
    logic [C_W-1:0] m_a;
    logic [3:0]     m_cnt;
    always @(posedge clk or posedge rs) begin
        if (rs) begin
            m_a   <= '0;
            m_cnt <= '0;
        end else if (!bus.s) begin
            m_a   <= bus.inA;
            m_cnt <= '0;
        end else if (m_a != '0) begin
            m_cnt <= m_cnt + {3'b000, m_a[0]};
            m_a   <= m_a >> 1;
        end
    end

    // Monitor: window width, scoreboard pop, counter result, gap behaviour.
    initial begin
        logic           prev_s;
        logic [C_W-1:0] prev_inA;
        logic [C_W-1:0] exp_w;
        int             hi;
        int             lo;
        bit             armed;
        bit             win_bad;
        prev_s = 1'b0; prev_inA = '0; exp_w = '0;
        hi = 0; lo = 0; armed = 0; win_bad = 0;
        forever begin
            @(negedge clk);
            if (rs) begin
                prev_s = 1'b0; hi = 0; lo = 0; armed = 0; win_bad = 0;
            end else begin
                if (bus.s && !prev_s) begin
                    if (q_exp.size() == 0) begin
                        chk_eq("sb_underflow", 32'd0, 32'd1);
                    end else begin
                        exp_w = q_exp.pop_front();
                        chk_eq("inA_before_s", prev_inA, exp_w);
                    end
                    if (armed) chk_eq("gap_ge2", (lo >= C_GAP) ? 1 : 0, 1);
                    hi = 1; win_bad = 0; armed = 0;
                end else if (bus.s) begin
                    hi++;
                end
                if (bus.s && (bus.ser_ready || !bus.busy)) win_bad = 1;
                if (!bus.s && prev_s) begin
                    chk_eq("s_width", hi, C_HOLD);
                    chk_eq("ctr_out", m_cnt, $countones(exp_w));
                    chk_eq("ready_busy_in_hold", win_bad, 0);
                    chk_eq("inA_hold", bus.inA, exp_w);
                    armed = 1; lo = 0;
                end
                if (!bus.s && armed) begin
                    lo++;
                    if (lo <= C_GAP)     chk_eq("ready_in_gap", bus.ser_ready, 0);
                    if (lo == C_GAP + 1) chk_eq("ready_after_gap", bus.ser_ready, 1);
                end
                prev_s   = bus.s;
                prev_inA = bus.inA;
            end
        end
    end

    // Called at a negedge with ser_ready=1; returns at the negedge where s=1.
    task automatic send_word(input logic [C_W-1:0] w, input int spacing);
        for (int i = C_W - 1; i >= 0; i--) begin
            if (i != C_W - 1) begin
                bus.ser_valid = 1'b0;
                repeat (spacing - 1) @(negedge clk);
            end
            if (i == 0) q_exp.push_back(w);
            bus.ser_valid = 1'b1;
            bus.ser_in    = w[i];
            @(negedge clk);
        end
        bus.ser_valid = 1'b0;
        // SETUP cycle: operand valid, s still low
        chk_eq("setup_ready", bus.ser_ready, 0);
        chk_eq("setup_busy",  bus.busy, 1);
        chk_eq("setup_s",     bus.s, 0);
        chk_eq("setup_inA",   bus.inA, w);
        @(negedge clk);
        chk_eq("hold_s",      bus.s, 1);
        chk_eq("hold_inA",    bus.inA, w);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.ser_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ser_ready) chk_eq("ready_timeout", bus.ser_ready, 1);
    endtask

    task automatic chk_idle(input string tag);
        chk_eq({tag, "_inA"},     bus.inA, 0);
        chk_eq({tag, "_s"},       bus.s, 0);
        chk_eq({tag, "_ready"},   bus.ser_ready, 1);
        chk_eq({tag, "_busy"},    bus.busy, 0);
        chk_eq({tag, "_overrun"}, bus.overrun, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rs            = 1'b1;
        bus.ser_in    = 1'b0;
        bus.ser_valid = 1'b0;
        bus.ovr_clr   = 1'b0;
        #1;
        chk_idle("rst");
        #21 rs = 1'b0;
        @(negedge clk);
        chk_idle("post_rst");

        // Word 1: back-to-back bits
        send_word(8'hAF, 1);
        chk_eq("ovr_quiet", bus.overrun, 0);
        wait_ready();

        // Word 2 with overrun exercise inside HOLD
        send_word(8'hEF, 1);
        bus.ser_valid = 1'b1; bus.ser_in = 1'b1;
        @(negedge clk);
        bus.ser_valid = 1'b0;
        chk_eq("ovr_set", bus.overrun, 1);
        @(negedge clk);
        chk_eq("ovr_sticky", bus.overrun, 1);
        bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.ovr_clr = 1'b0;
        chk_eq("ovr_clr", bus.overrun, 0);
        bus.ser_valid = 1'b1; bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.ser_valid = 1'b0; bus.ovr_clr = 1'b0;
        chk_eq("ovr_clr_wins", bus.overrun, 0);
        bus.ser_valid = 1'b1;
        @(negedge clk);
        bus.ser_valid = 1'b0;
        chk_eq("ovr_reset2", bus.overrun, 1);
        bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.ovr_clr = 1'b0;
        chk_eq("ovr_clr2", bus.overrun, 0);
        wait_ready();

        // Word 3: bits spaced three cycles apart
        send_word(8'hAF, 3);
        wait_ready();

        // Reset in the middle of HOLD
        send_word(8'h3C, 1);
        repeat (3) @(negedge clk);
        #2 rs = 1'b1;
        #1;
        chk_idle("async_rst");
        @(negedge clk);
        #2 rs = 1'b0;
        @(negedge clk);
        chk_idle("after_mid_rst");

        send_word(8'h01, 1);
        wait_ready();
        repeat (2) @(negedge clk);
        chk_eq("sb_empty", q_exp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ones_count_operand_feeder
`default_nettype wire
